// File: rtl/mem_common.sv
// Shared memory-interface definitions for the fetch path.
// Provides the line geometry and the request/response packets exchanged
// between the instruction cache and the L2 side.
//   t_mem_req_pkt : valid, id, addr        (miss request)
//   t_mem_rsp_pkt : valid, id, addr, data  (fill response, one full line)
package mem_common;

  localparam int ADDR_W     = 32;
  localparam int ID_W       = 8;
  localparam int LINE_BYTES = 64;
  localparam int LINE_W     = LINE_BYTES * 8;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } t_mem_req_pkt;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } t_mem_rsp_pkt;

endpackage

// File: rtl/l2_ic_rsp_gen_chk.sv
// Property checker for l2_ic_rsp_gen (compiled only when ASSERT is defined).
// Ports:
//   clk, reset  : clock and asynchronous active-high reset of the responder
//   rsp_valid   : response valid as driven to the icache
//   in_resp     : responder FSM is in its RESP state
//   occupancy   : write pointer minus read pointer of the request queue
`ifdef ASSERT
module l2_ic_rsp_gen_chk #(
  parameter int LATENCY = 8,
  parameter int DEPTH   = 4,
  parameter int PW      = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          rsp_valid,
  input logic          in_resp,
  input logic [PW-1:0] occupancy
);

  // A service latency below two leaves no room for the WAIT state.
  if (LATENCY < 2) begin : g_latency_chk
    $error("l2_ic_rsp_gen: LATENCY must be at least 2");
  end

  a_valid_only_in_resp: assert property (
    @(posedge clk) disable iff (reset) rsp_valid |-> in_resp);

  a_occupancy_bounded: assert property (
    @(posedge clk) disable iff (reset) occupancy <= PW'(DEPTH));

endmodule
`endif

// File: rtl/l2_ic_rsp_gen.sv
// L2-side responder for the instruction-cache miss interface.
// Every accepted miss request is answered, in request order, with the line
// held in a preloadable backing array after a fixed service latency.
// Ports:
//   clk, reset     : core clock, asynchronous active-high reset
//   ic_l2_req_pkt  : icache miss request (valid, id, addr); single-cycle pulse
//   l2_ic_rsp_pkt  : fill response (valid, id, addr, data); all-zero when idle
//   init_wr_en     : backing-array write strobe (preload)
//   init_wr_idx    : line index to write
//   init_wr_data   : line data to write
//   busy           : a request is queued or in service
//   ovf_err        : sticky, a request was dropped on a full queue
module l2_ic_rsp_gen
  import mem_common::*;
#(
  parameter int LATENCY   = 8,
  parameter int DEPTH     = 4,
  parameter int MEM_LINES = 256,
  parameter int LINE_OFS  = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  t_mem_req_pkt                 ic_l2_req_pkt,
  output t_mem_rsp_pkt                 l2_ic_rsp_pkt,
  input  logic                         init_wr_en,
  input  logic [$clog2(MEM_LINES)-1:0] init_wr_idx,
  input  logic [LINE_W-1:0]            init_wr_data,
  output logic                         busy,
  output logic                         ovf_err
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  // Enough bits to hold LATENCY-2, the WAIT countdown start value.
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1'b1);
  localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } t_q_ent;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  t_q_ent            q_r [DEPTH];
  t_q_ent            svc_r;
  t_q_ent            in_ent_s;
  t_q_ent            next_svc_s;
  logic              ovf_err_r;
  logic [LINE_W-1:0] mem_r [MEM_LINES];
  logic [IDX_W-1:0]  svc_idx_s;
  t_mem_rsp_pkt      rsp_s;

  logic empty_s;
  logic full_s;
  logic in_vld_s;
  logic avail_s;
  logic take_s;
  logic deq_s;
  logic bypass_s;
  logic enq_s;
  logic drop_s;

  // The wrap bit distinguishes full from empty when the index bits match.
  assign empty_s  = (rd_ptr_r == wr_ptr_r);
  assign full_s   = (rd_ptr_r[AW] != wr_ptr_r[AW]) &&
                    (rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]);
  assign in_vld_s = ic_l2_req_pkt.valid;
  assign avail_s  = !empty_s || in_vld_s;

  // A new request is taken only from IDLE or at the end of a RESP cycle.
  assign take_s   = ((state_r == ST_IDLE) || (state_r == ST_RESP)) && avail_s;
  assign deq_s    = take_s && !empty_s;
  // With an empty queue the incoming request goes straight into service.
  assign bypass_s = take_s && empty_s;
  // A full queue still accepts when an entry leaves in the same cycle.
  assign enq_s    = in_vld_s && !bypass_s && (!full_s || deq_s);
  assign drop_s   = in_vld_s && !bypass_s && full_s && !deq_s;

  assign in_ent_s.id   = ic_l2_req_pkt.id;
  assign in_ent_s.addr = ic_l2_req_pkt.addr;

  // Oldest available request: queue head, or the incoming one when empty.
  always_comb begin
    if (empty_s) begin
      next_svc_s = in_ent_s;
    end else begin
      next_svc_s = q_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Next-state and countdown logic of the service FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (avail_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (avail_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, latency counter and the request currently in service.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      svc_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (take_s) begin
        svc_r <= next_svc_s;
      end else begin
        svc_r <= svc_r;
      end
    end
  end

  // Request queue read/write pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
    end else begin
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Request queue storage; contents are meaningless outside the pointers.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      q_r[wr_ptr_r[AW-1:0]] <= in_ent_s;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_err_r <= 1'b0;
    end else if (drop_s) begin
      ovf_err_r <= 1'b1;
    end
  end

  // Backing array; deliberately not reset so preloaded lines survive reset.
  always_ff @(posedge clk) begin
    if (init_wr_en) begin
      mem_r[init_wr_idx] <= init_wr_data;
    end
  end

  assign svc_idx_s = svc_r.addr[LINE_OFS +: IDX_W];

  // Response is built from registered state only; the array read happens in
  // the RESP cycle, so a write on the same edge is not yet visible.
  always_comb begin
    rsp_s = '0;
    if (state_r == ST_RESP) begin
      rsp_s.valid = 1'b1;
      rsp_s.id    = svc_r.id;
      rsp_s.addr  = svc_r.addr;
      rsp_s.data  = mem_r[svc_idx_s];
    end else begin
      rsp_s.valid = 1'b0;
    end
  end

  assign l2_ic_rsp_pkt = rsp_s;
  assign busy          = (state_r != ST_IDLE) || !empty_s;
  assign ovf_err       = ovf_err_r;

`ifdef ASSERT
  logic [PW-1:0] occ_s;
  assign occ_s = wr_ptr_r - rd_ptr_r;

  l2_ic_rsp_gen_chk #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .PW      (PW)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .rsp_valid (l2_ic_rsp_pkt.valid),
    .in_resp   (state_r == ST_RESP),
    .occupancy (occ_s)
  );
`endif

endmodule

// File: doc/l2_ic_rsp_gen.md
Name: l2_ic_rsp_gen

Overview:
- L2-side responder for the instruction-cache miss interface.
- Accepts `t_mem_req_pkt` line-fill requests from `icache` (`ic_l2_req_pkt`) and returns one `t_mem_rsp_pkt` per request (`l2_ic_rsp_pkt`).
- Return data comes from a preloadable line array, after a fixed service latency, strictly in request order.
- Stands in for the full L2 in front-end-only and core-level sims. It is also the reference responder for the fetch path.

Parameters:
- `LATENCY`, 8: cycles from request-valid to response-valid, for an idle block. Legal range is 2 or more.
- `DEPTH`, 4: request queue entries. Must be a power of 2.
- `MEM_LINES`, 256: lines in the backing array.
- `LINE_OFS`, 6: byte-offset bits of a line; the line size comes from `mem_common`.

Ports:
- `clk`, input, 1: core clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `ic_l2_req_pkt`, input, `t_mem_req_pkt`: icache miss request. Fields used: `valid`, `id`, `addr`.
- `l2_ic_rsp_pkt`, output, `t_mem_rsp_pkt`: fill response. Fields: `valid`, `id`, `addr`, `data` (one full line).
- `init_wr_en`, input, 1: backing-array write strobe, used for preload.
- `init_wr_idx`, input, `$clog2(MEM_LINES)`: line index to write.
- `init_wr_data`, input, line width: line data to write.
- `busy`, output, 1: a request is queued or in service.
- `ovf_err`, output, 1: sticky flag; a request was dropped because the queue was full.

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE, queue empty, counter = 0, `ovf_err` = 0, `busy` = 0.
  - `l2_ic_rsp_pkt` = all zeros, including `valid` = 0.
  - The backing array is NOT reset.
  - Reset mid-operation discards all queued and in-service requests. No response is emitted for them.
- Request interface:
  - No ready or backpressure exists toward `icache`; a request is presented as a single-cycle `valid` pulse.
  - A request is enqueued at the clock edge ending its valid cycle.
- Line index = `addr[LINE_OFS +: $clog2(MEM_LINES)]`. Upper address bits are ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: leave IDLE when a request is available, meaning the queue is non-empty or an incoming valid request arrives this cycle (bypass).
    - Take the oldest request.
    - Load counter = `LATENCY`-2.
    - Go to WAIT.
  - WAIT: if counter == 0, go to RESP; else decrement the counter.
  - RESP, a single cycle:
    - Drive `l2_ic_rsp_pkt.valid` = 1, with `id` and `addr` of the serviced request and `data` = `array[line index]`, read in this cycle.
    - Then, if a request is available, take it, load counter = `LATENCY`-2 and go to WAIT. Otherwise go to IDLE.
- Timing:
  - Request valid in cycle T to an idle, empty block gives response valid in cycle T+`LATENCY`.
  - Back-to-back responses are spaced exactly `LATENCY` cycles apart.
- Ordering: strict FIFO. The response `id` equals the request `id`.
- Response `valid` is 0 in every cycle other than RESP. Payload fields are don't-care when `valid` = 0, but are held at zero for clean waveforms.
- Queue: circular buffer with `$clog2(DEPTH)+1`-bit read/write pointers (wrap bit); full/empty are derived from the pointers.
  - Taking a request while the queue is empty and an incoming request is valid (bypass): the request never occupies an entry.
  - Enqueue and dequeue in the same cycle: occupancy is unchanged. This is legal even when the queue is full.
  - Full, with no dequeue in the same cycle, and a valid request arrives:
    - The request is dropped.
    - `ovf_err` sets the next cycle and stays set until reset.
    - Queue contents are unaffected.
- Backing array:
  - Write when `init_wr_en` = 1, at the clock edge.
  - Same-cycle write and RESP read of the same line: the response carries the OLD data (read-before-write).
- `busy` = (state != IDLE) | queue non-empty. It is combinational from state.
- Assertions (under `ASSERT`):
  - Response `valid` only in RESP.
  - Queue occupancy never exceeds `DEPTH`.
  - `LATENCY` >= 2 (elaboration check).

Test Plan:
- Preload line 3 = `0xA5..A5`; req id=1, addr=`0xC0` in cycle 10 → response valid only in cycle 18 with id=1, addr=`0xC0`, data=`0xA5..A5`; `busy` 1 in cycles 11-18, 0 from 19.
- Reqs id=1,2,3 in consecutive cycles 10, 11, 12 → responses in cycles 18, 26, 34 carrying ids 1, 2, 3; no extra valids.
- `DEPTH`=4: 6 reqs in consecutive cycles starting in cycle 10 (first bypasses, 4 queue) → 6th dropped; `ovf_err`=1 from cycle 16 onward; exactly 5 responses with ids 1-5.
- Queue full and a RESP-cycle dequeue coincides with a new request → request accepted, `ovf_err` stays 0, response order preserved.
- Reset asserted in mid-WAIT with 2 queued → all outputs zero immediately (async); after release no responses; preloaded data intact for a subsequent req.
- `init_wr_en` to line 3 with `0x5A..5A` in the same cycle as a RESP for line 3 → response data `0xA5..A5`; next req to line 3 returns `0x5A..5A`.
